// File: rtl/ex_alu_stage.sv
// ex_alu_stage -- RV32I execute stage.
// It computes AND/OR/ADD/SUB on two operands and holds each result, with its
// zero flag, illegal flag and destination tag, in a 2-entry in-order output
// buffer. Both sides of the buffer use valid/ready handshakes.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             operation handshake (in_ready is state-only)
//   ALU_Cntrl, op_a, op_b, rd_in    operation code, operands, destination tag
//   flush                           drop all buffered entries (branch mispredict)
//   out_valid / out_ready           head entry handshake
//   out_result, out_zero,
//   out_illegal, out_rd             head entry fields
//   retired_cnt                     number of pops since reset (wraps)
//
// Occupancy states:
//   state | meaning
//   EMPTY | no entries, out_valid low
//   ONE   | head entry valid, tail slot free
//   FULL  | head and tail valid, in_ready low
module ex_alu_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_Cntrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [4:0]       out_rd,
  output logic [CNT_W-1:0] retired_cnt
);

  // Entry layout, from MSB to LSB: {illegal, zero, rd[4:0], result[WIDTH-1:0]}
  localparam int EW = WIDTH + 7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t             r_occ;
  logic [EW-1:0]    r_head;
  logic [EW-1:0]    r_tail;
  logic [CNT_W-1:0] r_retired;

  logic             w_accept;
  logic             w_pop;
  logic [WIDTH-1:0] w_result;
  logic             w_illegal;
  logic             w_zero;
  logic [EW-1:0]    w_entry;

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (ALU_Cntrl)
      4'b0000: w_result = op_a & op_b;
      4'b0001: w_result = op_a | op_b;
      4'b0010: w_result = op_a + op_b;
      4'b0110: w_result = op_a - op_b;
      default: w_illegal = 1'b1;   // result stays 0, so zero reads 1
    endcase
  end

  assign w_zero   = (w_result == '0);
  assign w_entry  = {w_illegal, w_zero, rd_in, w_result};

  assign in_ready  = (r_occ != FULL);
  assign out_valid = (r_occ != EMPTY);
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ     <= EMPTY;
      r_head    <= '0;
      r_tail    <= '0;
      r_retired <= '0;
    end else begin
      if (flush) begin
        // Payload registers keep their last value; only occupancy clears.
        r_occ <= EMPTY;
      end else begin
        case (r_occ)
          EMPTY: begin
            if (w_accept) begin
              r_head <= w_entry;
              r_occ  <= ONE;
            end
          end
          ONE: begin
            if (w_accept && w_pop) begin
              r_head <= w_entry;     // new entry replaces the departing head
            end else if (w_accept) begin
              r_tail <= w_entry;
              r_occ  <= FULL;
            end else if (w_pop) begin
              r_occ  <= EMPTY;
            end
          end
          FULL: begin
            if (w_pop) begin
              r_head <= r_tail;
              r_occ  <= ONE;
            end
          end
          default: r_occ <= EMPTY;
        endcase
      end
      if (w_pop) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign out_result  = r_head[WIDTH-1:0];
  assign out_rd      = r_head[WIDTH+4:WIDTH];
  assign out_zero    = r_head[WIDTH+5];
  assign out_illegal = r_head[WIDTH+6];
  assign retired_cnt = r_retired;

endmodule

// File: tb/tb_ex_alu_stage.sv
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALU_Cntrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;
  logic [4:0]  out_rd;
  logic [15:0] retired_cnt;

  int total = 0;
  int bad   = 0;

  // Scoreboard entries: {illegal, zero, rd[4:0], result[31:0]}
  logic [38:0] q[$];
  logic [15:0] m_cnt = '0;

  ex_alu_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_Cntrl(ALU_Cntrl), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal),
    .out_rd(out_rd), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [38:0] ref_entry(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] r;
    logic        il;
    r  = '0;
    il = 1'b0;
    if (c == 4'b0000)      r = a & b;
    else if (c == 4'b0001) r = a | b;
    else if (c == 4'b0010) r = a + b;
    else if (c == 4'b0110) r = a - b;
    else                   il = 1'b1;
    return {il, (r == 32'd0), rd, r};
  endfunction

  task automatic check_state();
    logic [38:0] h;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    chk("retired_cnt", retired_cnt, m_cnt);
    if (q.size() != 0) begin
      h = q[0];
      chk("out_result", out_result, h[31:0]);
      chk("out_rd", out_rd, h[36:32]);
      chk("out_zero", out_zero, h[37]);
      chk("out_illegal", out_illegal, h[38]);
    end
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic cyc(input logic v, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd,
                     input logic f, input logic ordy);
    logic acc, pp;
    in_valid = v; ALU_Cntrl = c; op_a = a; op_b = b; rd_in = rd;
    flush = f; out_ready = ordy;
    check_state();
    acc = v && (q.size() < 2) && !f;
    pp  = (q.size() != 0) && ordy && !f;
    @(posedge clk);
    if (f) begin
      q.delete();
    end else begin
      if (pp) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (acc) q.push_back(ref_entry(c, a, b, rd));
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, ordy);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; ALU_Cntrl = '0; op_a = '0; op_b = '0;
    rd_in = '0; flush = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_zero", out_zero, 1'b0);
    chk("rst_out_illegal", out_illegal, 1'b0);
    chk("rst_out_rd", out_rd, 5'd0);
    chk("rst_retired", retired_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1'b1);

    // ADD 5+7
    cyc(1'b1, 4'b0010, 32'd5, 32'd7, 5'd3, 1'b0, 1'b1);
    chk("add_5_7", out_result, 32'd12);
    chk("add_5_7_zero", out_zero, 1'b0);
    // Branch SUB equal, then not equal (back-to-back accept while popping)
    cyc(1'b1, 4'b0110, 32'd9, 32'd9, 5'd4, 1'b0, 1'b1);
    chk("sub_eq", out_result, 32'd0);
    chk("sub_eq_zero", out_zero, 1'b1);
    cyc(1'b1, 4'b0110, 32'd9, 32'd10, 5'd5, 1'b0, 1'b1);
    chk("sub_ne", out_result, 32'hFFFF_FFFF);
    // Wrap ADD and AND
    cyc(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b0, 1'b1);
    chk("add_wrap_zero", out_zero, 1'b1);
    cyc(1'b1, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7, 1'b0, 1'b1);
    chk("and_pat", out_result, 32'hF000_F000);
    idle(1'b1);
    idle(1'b1);
    chk("retired_5", retired_cnt, 16'd5);

    // Backpressure: AND, OR fill the buffer, third op is held
    cyc(1'b1, 4'b0000, 32'h0000_00FF, 32'h0000_0F0F, 5'd8, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 32'h1200_0000, 32'h0034_0000, 5'd9, 1'b0, 1'b0);
    chk("bp_full_ready", in_ready, 1'b0);
    cyc(1'b1, 4'b0010, 32'd100, 32'd23, 5'd10, 1'b0, 1'b0);
    cyc(1'b1, 4'b0010, 32'd100, 32'd23, 5'd10, 1'b0, 1'b1);
    cyc(1'b1, 4'b0010, 32'd100, 32'd23, 5'd10, 1'b0, 1'b1);
    cyc(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    idle(1'b1);
    chk("bp_retired", retired_cnt, 16'd8);

    // Flush with FULL buffer and a valid input
    cyc(1'b1, 4'b0001, 32'd1, 32'd2, 5'd11, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 32'd4, 32'd8, 5'd12, 1'b0, 1'b0);
    cyc(1'b1, 4'b0010, 32'd1, 32'd1, 5'd13, 1'b1, 1'b1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_retired", retired_cnt, 16'd8);
    // Illegal code
    cyc(1'b1, 4'b1111, 32'd3, 32'd4, 5'd14, 1'b0, 1'b0);
    chk("ill_result", out_result, 32'd0);
    chk("ill_flag", out_illegal, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset while FULL and popping
    cyc(1'b1, 4'b0010, 32'd10, 32'd20, 5'd15, 1'b0, 1'b0);
    cyc(1'b1, 4'b0110, 32'd50, 32'd8, 5'd16, 1'b0, 1'b0);
    out_ready = 1'b1; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_result", out_result, 32'd0);
    chk("mid_rst_zero", out_zero, 1'b0);
    chk("mid_rst_rd", out_rd, 5'd0);
    chk("mid_rst_retired", retired_cnt, 16'd0);
    chk("mid_rst_ready", in_ready, 1'b1);
    q.delete();
    m_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 4'b0001, 32'hA000_0000, 32'h0000_000B, 5'd17, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
